// File: rtl/mpc_sequencer.sv
// mpc_sequencer: micro-program counter sequencer for a Mic-1 style control store.
// Define MPC_STEP_EN to add a single-step input that gates every advance of MPC.
module mpc_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  Next_ADDR,
    input  logic [2:0]  JAM,
    input  logic        N,
    input  logic        Z,
    input  logic [7:0]  MBR,
    input  logic        mem_busy,
`ifdef MPC_STEP_EN
    input  logic        step,
`endif
    output logic [8:0]  MPC,
    output logic        READ,
    output logic        halted,
    output logic [15:0] cycles
);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, HALT} state_t;

    state_t      state;
    state_t      state_next;
    logic [8:0]  mpc_next;
    logic [15:0] cycles_next;
    logic [8:0]  jump_addr;
    logic        advance;

    // JMPC merges the opcode by OR, so the two address halves never interact.
    always_comb begin
        jump_addr[7:0] = Next_ADDR[7:0] | (JAM[2] ? MBR : 8'h00);
        jump_addr[8]   = Next_ADDR[8] | (JAM[1] & N) | (JAM[0] & Z);
    end

`ifdef MPC_STEP_EN
    logic step_prev;
    logic step_pending;
    logic step_rise;

    assign step_rise = step & ~step_prev;
    assign advance   = ~mem_busy & (step_rise | step_pending);

    // A step that lands while memory is busy is remembered (one deep) until it can be used.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_prev    <= 1'b0;
            step_pending <= 1'b0;
        end else begin
            step_prev <= step;
            if (state == RUN) begin
                if (advance)
                    step_pending <= 1'b0;
                else if (step_rise && mem_busy)
                    step_pending <= 1'b1;
            end
        end
    end
`else
    assign advance = ~mem_busy;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            MPC    <= 9'h000;
            cycles <= 16'h0000;
        end else begin
            state  <= state_next;
            MPC    <= mpc_next;
            cycles <= cycles_next;
        end
    end

    always_comb begin
        state_next  = state;
        mpc_next    = MPC;
        cycles_next = cycles;
        READ        = 1'b1;
        halted      = 1'b0;
        case (state)
            IDLE: begin
                READ       = 1'b0;
                mpc_next   = 9'h000;
                state_next = PRIME;
            end
            PRIME: begin
                mpc_next   = 9'h000;
                state_next = RUN;
            end
            RUN: begin
                if (advance) begin
                    // An unconditional jump to itself can never leave, so park in HALT.
                    if (JAM == 3'b000 && Next_ADDR == MPC) begin
                        state_next = HALT;
                    end else begin
                        mpc_next = jump_addr;
                        if (cycles != 16'hFFFF)
                            cycles_next = cycles + 16'd1;
                    end
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mpc_sequencer.sv
// Self-checking bench for mpc_sequencer: a reference model fills a scoreboard queue
// each cycle and the DUT outputs are compared against it after every rising edge.
module tb_mpc_sequencer;

    typedef struct {
        logic [8:0]  mpc;
        logic        read;
        logic        halted;
        logic [15:0] cycles;
    } expect_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  Next_ADDR;
    logic [2:0]  JAM;
    logic        N;
    logic        Z;
    logic [7:0]  MBR;
    logic        mem_busy;
    logic        step;
    logic [8:0]  MPC;
    logic        READ;
    logic        halted;
    logic [15:0] cycles;

    int testsRun = 0;
    int testsFailed = 0;
    expect_t scoreboard[$];

    int          mState;
    logic [8:0]  mMpc;
    logic [15:0] mCycles;
    logic        mStepPrev;
    logic        mPending;

    always #5 clk = ~clk;

    mpc_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .Next_ADDR (Next_ADDR),
        .JAM       (JAM),
        .N         (N),
        .Z         (Z),
        .MBR       (MBR),
        .mem_busy  (mem_busy),
`ifdef MPC_STEP_EN
        .step      (step),
`endif
        .MPC       (MPC),
        .READ      (READ),
        .halted    (halted),
        .cycles    (cycles)
    );

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [8:0] modelNext(input logic [8:0] na, input logic [2:0] jam,
                                             input logic n, input logic z, input logic [7:0] mbr);
        logic [7:0] opc;
        opc = jam[2] ? mbr : 8'h00;
        return {na[8] | (jam[1] & n) | (jam[0] & z), na[7:0] | opc};
    endfunction

    // Models one rising edge: 0=IDLE 1=PRIME 2=RUN 3=HALT.
    task automatic modelEdge(input logic rst, input logic [8:0] na, input logic [2:0] jam, input logic n,
                             input logic z, input logic [7:0] mbr, input logic busy, input logic stp);
        logic rise;
        logic adv;
        rise = stp & ~mStepPrev;
        if (rst) begin
            mState = 0; mMpc = 9'h000; mCycles = 16'h0000; mStepPrev = 1'b0; mPending = 1'b0;
        end else begin
            adv = ~busy;
`ifdef MPC_STEP_EN
            adv = ~busy & (rise | mPending);
`endif
            case (mState)
                0: mState = 1;
                1: mState = 2;
                2: begin
`ifdef MPC_STEP_EN
                    if (adv) mPending = 1'b0;
                    else if (rise && busy) mPending = 1'b1;
`endif
                    if (adv) begin
                        if (jam == 3'b000 && na == mMpc) mState = 3;
                        else begin
                            mMpc = modelNext(na, jam, n, z, mbr);
                            if (mCycles != 16'hFFFF) mCycles = mCycles + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
            mStepPrev = stp;
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [8:0] na, input logic [2:0] jam, input logic n,
                                 input logic z, input logic [7:0] mbr, input logic busy, input logic stp,
                                 input bit check);
        expect_t e;
        expect_t got;
        @(negedge clk);
        reset = rst; Next_ADDR = na; JAM = jam; N = n; Z = z; MBR = mbr; mem_busy = busy; step = stp;
        modelEdge(rst, na, jam, n, z, mbr, busy, stp);
        if (check) begin
            e.mpc = mMpc; e.read = (mState != 0); e.halted = (mState == 3); e.cycles = mCycles;
            scoreboard.push_back(e);
        end
        @(posedge clk);
        #1;
        if (check) begin
            got = scoreboard.pop_front();
            checkOutput("mpc", {7'd0, MPC}, {7'd0, got.mpc});
            checkOutput("read", {15'd0, READ}, {15'd0, got.read});
            checkOutput("halted", {15'd0, halted}, {15'd0, got.halted});
            checkOutput("cycles", cycles, got.cycles);
        end
    endtask

    // One advancing microinstruction; in single-step builds a fresh step edge is generated first.
    task automatic advanceOnce(input logic [8:0] na, input logic [2:0] jam, input logic n,
                               input logic z, input logic [7:0] mbr);
`ifdef MPC_STEP_EN
        applyStimulus(1'b0, na, jam, n, z, mbr, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, na, jam, n, z, mbr, 1'b0, 1'b1, 1'b1);
`else
        applyStimulus(1'b0, na, jam, n, z, mbr, 1'b0, 1'b0, 1'b1);
`endif
    endtask

    initial begin
        reset = 1'b1; Next_ADDR = '0; JAM = '0; N = 1'b0; Z = 1'b0; MBR = '0; mem_busy = 1'b0; step = 1'b0;
        mState = 0; mMpc = '0; mCycles = '0; mStepPrev = 1'b0; mPending = 1'b0;

        // Reset held three cycles, with busy and step active to show reset wins.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 9'h0AA, 3'b000, 1'b0, 1'b0, 8'h00, 1'b1, i[0], 1'b1);
        checkOutput("reset_mpc", {7'd0, MPC}, 16'h0000);
        checkOutput("reset_read", {15'd0, READ}, 16'h0000);

        applyStimulus(1'b0, 9'h005, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("prime_read", {15'd0, READ}, 16'h0001);
        checkOutput("prime_mpc", {7'd0, MPC}, 16'h0000);
        applyStimulus(1'b0, 9'h005, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        advanceOnce(9'h005, 3'b000, 1'b0, 1'b0, 8'h00);
        checkOutput("first_load", {7'd0, MPC}, 16'h0005);

        advanceOnce(9'h012, 3'b100, 1'b0, 1'b0, 8'h60);
        checkOutput("jmpc_or", {7'd0, MPC}, 16'h0072);
        advanceOnce(9'h0FF, 3'b100, 1'b0, 1'b0, 8'h0F);
        checkOutput("jmpc_nocarry", {7'd0, MPC}, 16'h00FF);
        advanceOnce(9'h034, 3'b010, 1'b1, 1'b0, 8'h00);
        checkOutput("jamn_taken", {7'd0, MPC}, 16'h0134);
        advanceOnce(9'h034, 3'b010, 1'b0, 1'b0, 8'h00);
        checkOutput("jamn_not", {7'd0, MPC}, 16'h0034);
        advanceOnce(9'h034, 3'b011, 1'b1, 1'b1, 8'h00);
        checkOutput("jamn_jamz", {7'd0, MPC}, 16'h0134);
        advanceOnce(9'h030, 3'b111, 1'b1, 1'b0, 8'h0B);
        checkOutput("jmpc_jamn", {7'd0, MPC}, 16'h013B);
        advanceOnce(9'h1FF, 3'b000, 1'b0, 1'b0, 8'h00);
        checkOutput("mpc_max", {7'd0, MPC}, 16'h01FF);

        // Four busy cycles freeze MPC; in step builds a step edge arrives mid-stall.
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 9'h010, 3'b000, 1'b0, 1'b0, 8'h00, 1'b1, (i >= 1), 1'b1);
        checkOutput("busy_mpc", {7'd0, MPC}, 16'h01FF);
        checkOutput("busy_cycles", cycles, 16'd8);
        checkOutput("busy_read", {15'd0, READ}, 16'h0001);
        applyStimulus(1'b0, 9'h010, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        checkOutput("busy_release", {7'd0, MPC}, 16'h0010);
        checkOutput("busy_rel_cycles", cycles, 16'd9);

`ifdef MPC_STEP_EN
        applyStimulus(1'b0, 9'h020, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b0, 9'h020, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        checkOutput("step_held", {7'd0, MPC}, 16'h0020);
        checkOutput("step_held_cycles", cycles, 16'd10);
`endif

        advanceOnce(9'h050, 3'b000, 1'b0, 1'b0, 8'h00);
        advanceOnce(9'h050, 3'b000, 1'b0, 1'b0, 8'h00);
        checkOutput("halt_flag", {15'd0, halted}, 16'h0001);
        checkOutput("halt_mpc", {7'd0, MPC}, 16'h0050);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 9'h077, 3'b001, 1'b1, 1'b1, 8'hFF, 1'b0, i[0], 1'b1);
        checkOutput("halt_hold", {7'd0, MPC}, 16'h0050);
        applyStimulus(1'b1, 9'h077, 3'b000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        checkOutput("halt_reset_mpc", {7'd0, MPC}, 16'h0000);
        checkOutput("halt_reset_cycles", cycles, 16'h0000);
        checkOutput("halt_reset_halted", {15'd0, halted}, 16'h0000);

        // Randomised run against the model.
        for (int i = 0; i < 80; i++)
            applyStimulus(1'b0, 9'($urandom_range(0, 511)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 1)), 1'b1);

`ifndef MPC_STEP_EN
        // Saturation: alternate between two addresses long enough to pass 16'hFFFF loads.
        applyStimulus(1'b1, 9'h000, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 65540; i++)
            applyStimulus(1'b0, mMpc ^ 9'h001, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, mMpc ^ 9'h001, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("cycles_saturate", cycles, 16'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
